// File: rtl/ldpc_backsub_pkg.sv
// Shared types and helpers for the LDPC parity back-substitution engine.
// Widths are derived from the default configuration; the top re-derives them from its own parameters.
package ldpc_backsub_pkg;

   localparam int unsigned LP_WIDTH     = 8;
   localparam int unsigned LP_MAX_WORDS = 1024;
   localparam int unsigned LP_NUM_CH    = 4;
   localparam int unsigned LP_CHAN_W    = (LP_NUM_CH > 1) ? $clog2(LP_NUM_CH) : 1;
   localparam int unsigned LP_CNT_W     = $clog2(LP_MAX_WORDS + 1);

   typedef logic [LP_CHAN_W-1:0] chan_t;
   typedef logic [LP_CNT_W-1:0]  cnt_t;

   typedef struct packed {
      cnt_t                cnt;
      cnt_t                len;
      logic [LP_WIDTH-1:0] acc;
   } ch_state_t;

   function automatic int unsigned chan_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // A requested length of zero or beyond the frame buffer means "full-size frame".
   function automatic int unsigned clamp_len(input int unsigned n, input int unsigned max_words);
      return ((n == 0) || (n > max_words)) ? max_words : n;
   endfunction

endpackage

// File: rtl/ldpc_parity_backsub_if.sv
// Stream interface of the back-substitution engine: syndrome input beat plus framing,
// parity output beat, and the synchronous abort.
interface ldpc_parity_backsub_if
   import ldpc_backsub_pkg::*;
#(
   parameter int unsigned WIDTH     = LP_WIDTH,
   parameter int unsigned MAX_WORDS = LP_MAX_WORDS,
   parameter int unsigned NUM_CH    = LP_NUM_CH
) ();

   localparam int unsigned CHAN_W = chan_width(NUM_CH);
   localparam int unsigned LEN_W  = $clog2(MAX_WORDS + 1);

   logic              i_clear;
   logic [WIDTH-1:0]  i_in_data;
   logic [CHAN_W-1:0] i_in_chan;
   logic [LEN_W-1:0]  i_num_words;
   logic [WIDTH-1:0]  i_seed;
   logic              i_seed_en;
   logic              i_in_valid;
   logic              o_in_ready;
   logic [WIDTH-1:0]  o_out_data;
   logic [CHAN_W-1:0] o_out_chan;
   logic              o_out_last;
   logic              o_out_valid;
   logic              i_out_ready;

   modport master (
      output i_clear, i_in_data, i_in_chan, i_num_words, i_seed, i_seed_en, i_in_valid,
      output i_out_ready,
      input  o_in_ready, o_out_data, o_out_chan, o_out_last, o_out_valid
   );

   modport slave (
      input  i_clear, i_in_data, i_in_chan, i_num_words, i_seed, i_seed_en, i_in_valid,
      input  i_out_ready,
      output o_in_ready, o_out_data, o_out_chan, o_out_last, o_out_valid
   );

endinterface

// File: rtl/ldpc_backsub_out_reg.sv
// One-entry valid/ready output register carrying {data, chan, last}.
// Accepted-but-discarded beats consume the input slot without being presented downstream.
module ldpc_backsub_out_reg #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned CHAN_W = 2
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_clear,
   input  logic              i_in_valid,
   input  logic              i_in_discard,
   input  logic [WIDTH-1:0]  i_in_data,
   input  logic [CHAN_W-1:0] i_in_chan,
   input  logic              i_in_last,
   output logic              o_in_ready,
   output logic [WIDTH-1:0]  o_out_data,
   output logic [CHAN_W-1:0] o_out_chan,
   output logic              o_out_last,
   output logic              o_out_valid,
   input  logic              i_out_ready
);

   logic              r_valid;
   logic [WIDTH-1:0]  r_data;
   logic [CHAN_W-1:0] r_chan;
   logic              r_last;
   logic              w_load;

   // Reset is folded in so upstream sees no acceptance while the block is held in reset.
   assign o_in_ready = i_reset_n && !i_clear && (!r_valid || i_out_ready);
   assign w_load     = i_in_valid && o_in_ready && !i_in_discard;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
         r_last  <= 1'b0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_data  <= i_in_data;
         r_chan  <= i_in_chan;
         r_last  <= i_in_last;
      end else if (i_out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_out_valid = r_valid;
   assign o_out_data  = r_data;
   assign o_out_chan  = r_chan;
   assign o_out_last  = r_last;

endmodule

// File: rtl/ldpc_parity_backsub.sv
// Multi-channel dual-diagonal back-substitution: per-channel running XOR over a frame,
// emitting the prefix XOR of each accepted syndrome word one cycle later.
module ldpc_parity_backsub
   import ldpc_backsub_pkg::*;
#(
   parameter int unsigned WIDTH     = LP_WIDTH,
   parameter int unsigned MAX_WORDS = LP_MAX_WORDS,
   parameter int unsigned NUM_CH    = LP_NUM_CH
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   ldpc_parity_backsub_if.slave  bus
);

   localparam int unsigned CHAN_W = chan_width(NUM_CH);
   localparam int unsigned LEN_W  = $clog2(MAX_WORDS + 1);

   typedef struct packed {
      logic [LEN_W-1:0] cnt;
      logic [LEN_W-1:0] len;
      logic [WIDTH-1:0] acc;
   } state_t;

   logic [NUM_CH-1:0] w_hit;
   state_t            w_masked [NUM_CH];
   state_t            w_cur;
   state_t            w_upd;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_chan_ok;
   logic              w_first;
   logic              w_last;
   logic [LEN_W-1:0]  w_eff_len;
   logic [WIDTH-1:0]  w_eff_acc;
   logic [WIDTH-1:0]  w_out_word;
   logic [WIDTH-1:0]  w_out_data;
   logic [CHAN_W-1:0] w_out_chan;
   logic              w_out_last;
   logic              w_out_valid;

   assign w_accept  = bus.i_in_valid && w_in_ready;
   assign w_chan_ok = |w_hit;

   // Channel state lives in flops so a beat sees the previous beat's update with no stall.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         state_t r_state;

         assign w_hit[gi]    = (32'(bus.i_in_chan) == gi);
         assign w_masked[gi] = w_hit[gi] ? r_state : '0;

         always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
               r_state <= '0;
            end else if (bus.i_clear) begin
               r_state <= '0;
            end else if (w_accept && w_hit[gi]) begin
               r_state <= w_upd;
            end
         end
      end
   endgenerate

   always_comb begin
      w_cur = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_cur = w_cur | w_masked[c];
      end
   end

   // A zero count marks the first beat: framing comes from the inputs, not stored state.
   assign w_first    = (w_cur.cnt == '0);
   assign w_eff_len  = w_first ? LEN_W'(clamp_len(32'(bus.i_num_words), MAX_WORDS)) : w_cur.len;
   assign w_eff_acc  = w_first ? (bus.i_seed_en ? bus.i_seed : '0) : w_cur.acc;
   assign w_out_word = w_eff_acc ^ bus.i_in_data;
   assign w_last     = (w_cur.cnt == (w_eff_len - LEN_W'(1)));

   always_comb begin
      w_upd     = '0;
      w_upd.len = w_eff_len;
      if (!w_last) begin
         w_upd.cnt = w_cur.cnt + LEN_W'(1);
         w_upd.acc = w_out_word;
      end
   end

   ldpc_backsub_out_reg #(
      .WIDTH  (WIDTH),
      .CHAN_W (CHAN_W)
   ) u_out_reg (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_clear      (bus.i_clear),
      .i_in_valid   (bus.i_in_valid),
      .i_in_discard (!w_chan_ok),
      .i_in_data    (w_out_word),
      .i_in_chan    (bus.i_in_chan),
      .i_in_last    (w_last),
      .o_in_ready   (w_in_ready),
      .o_out_data   (w_out_data),
      .o_out_chan   (w_out_chan),
      .o_out_last   (w_out_last),
      .o_out_valid  (w_out_valid),
      .i_out_ready  (bus.i_out_ready)
   );

   assign bus.o_in_ready  = w_in_ready;
   assign bus.o_out_data  = w_out_data;
   assign bus.o_out_chan  = w_out_chan;
   assign bus.o_out_last  = w_out_last;
   assign bus.o_out_valid = w_out_valid;

endmodule

// File: tb/tb_ldpc_parity_backsub.sv
// Bench for ldpc_parity_backsub: directed frames plus randomized interleaved traffic,
// checked against a per-channel frame model that recomputes each prefix XOR from scratch.
module tb_ldpc_parity_backsub;
   import ldpc_backsub_pkg::*;

   localparam int unsigned TB_WIDTH = 8;
   localparam int unsigned TB_MAXW  = 1024;
   localparam int unsigned TB_NCH   = 3;
   localparam int unsigned TB_CHW   = chan_width(TB_NCH);
   localparam int unsigned TB_LENW  = $clog2(TB_MAXW + 1);

   typedef struct {
      int unsigned data;
      int unsigned chan;
      int unsigned last;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ldpc_parity_backsub_if #(.WIDTH(TB_WIDTH), .MAX_WORDS(TB_MAXW), .NUM_CH(TB_NCH)) bus ();

   ldpc_parity_backsub #(.WIDTH(TB_WIDTH), .MAX_WORDS(TB_MAXW), .NUM_CH(TB_NCH)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   int          checks = 0;
   int          errors = 0;
   beat_t       exp_q[$];
   beat_t       obs_q[$];
   int unsigned frm_len  [TB_NCH];
   int unsigned frm_seed [TB_NCH];
   int unsigned frm_words[TB_NCH][$];
   bit          rand_ready = 1'b0;
   bit          rdy_force  = 1'b1;
   bit          rdy_rand   = 1'b1;

   assign bus.i_out_ready = rand_ready ? rdy_rand : rdy_force;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Frame model: each output is the seed XOR every word so far in the channel's frame.
   function automatic void model_accept(input int unsigned ch, input int unsigned d,
                                        input int unsigned nw, input int unsigned sd, input bit se);
      int unsigned x;
      beat_t       b;
      if (ch >= TB_NCH) return;
      if (frm_words[ch].size() == 0) begin
         frm_len[ch]  = ((nw == 0) || (nw > TB_MAXW)) ? TB_MAXW : nw;
         frm_seed[ch] = se ? sd : 0;
      end
      frm_words[ch].push_back(d);
      x = frm_seed[ch];
      for (int k = 0; k < frm_words[ch].size(); k++) x = x ^ frm_words[ch][k];
      b.data = x;
      b.chan = ch;
      b.last = (frm_words[ch].size() == frm_len[ch]) ? 1 : 0;
      exp_q.push_back(b);
      if (b.last != 0) frm_words[ch].delete();
   endfunction

   function automatic void model_abort();
      for (int c = 0; c < TB_NCH; c++) frm_words[c].delete();
   endfunction

   task automatic send(input int unsigned ch, input int unsigned d, input int unsigned nw,
                       input int unsigned sd, input bit se);
      bit ok;
      ok = 1'b0;
      bus.i_in_chan   = TB_CHW'(ch);
      bus.i_in_data   = TB_WIDTH'(d);
      bus.i_num_words = TB_LENW'(nw);
      bus.i_seed      = TB_WIDTH'(sd);
      bus.i_seed_en   = se;
      bus.i_in_valid  = 1'b1;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (bus.o_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) model_accept(ch, d & 32'hFF, nw, sd & 32'hFF, se);
      else    chk("send_ready_timeout", 32'(bus.o_in_ready), 1);
      @(posedge clk); #1;
      bus.i_in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(negedge clk);
      chk("drain_pending", 32'(exp_q.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic chk_obs(input string tag, input int unsigned idx, input int unsigned d,
                          input int unsigned l);
      if (idx < 32'(obs_q.size())) begin
         chk({tag, "_data"}, obs_q[idx].data, d);
         chk({tag, "_last"}, obs_q[idx].last, l);
      end else begin
         chk({tag, "_count"}, 32'(obs_q.size()), idx + 1);
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      rdy_rand = ($urandom_range(0, 2) != 0);
   end

   // Output monitor: one line per delivered beat, compared in order against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n && bus.o_out_valid && bus.i_out_ready) begin
         beat_t o;
         beat_t e;
         o.data = 32'(bus.o_out_data);
         o.chan = 32'(bus.o_out_chan);
         o.last = 32'(bus.o_out_last);
         obs_q.push_back(o);
         $display("OUT ch=%0d data=0x%02h last=%0d", o.chan, o.data, o.last);
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(bus.o_out_valid), 0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", o.data, e.data);
            chk("out_chan", o.chan, e.chan);
            chk("out_last", o.last, e.last);
         end
      end
   end

   initial begin
      int unsigned nl;
      int unsigned ch;
      bus.i_clear     = 1'b0;
      bus.i_in_valid  = 1'b0;
      bus.i_in_data   = '0;
      bus.i_in_chan   = '0;
      bus.i_num_words = '0;
      bus.i_seed      = '0;
      bus.i_seed_en   = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.o_out_valid), 0);
      chk("rst_data",  32'(bus.o_out_data), 0);
      chk("rst_chan",  32'(bus.o_out_chan), 0);
      chk("rst_last",  32'(bus.o_out_last), 0);
      chk("rst_ready", 32'(bus.o_in_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(bus.o_in_ready), 1);
      @(posedge clk); #1;

      // Basic frame, then a length-1 frame
      obs_q.delete();
      send(0, 'h01, 4, 0, 0); send(0, 'h02, 4, 0, 0);
      send(0, 'h04, 4, 0, 0); send(0, 'h08, 4, 0, 0);
      send(0, 'h10, 1, 0, 0);
      drain();
      chk_obs("basic0", 0, 'h01, 0); chk_obs("basic1", 1, 'h03, 0);
      chk_obs("basic2", 2, 'h07, 0); chk_obs("basic3", 3, 'h0F, 1);
      chk_obs("basic4", 4, 'h10, 1);

      // Seeded frame
      obs_q.delete();
      send(0, 'h0F, 3, 'hA5, 1); send(0, 'hF0, 3, 'hA5, 1); send(0, 'hFF, 3, 'hA5, 1);
      drain();
      chk_obs("seed0", 0, 'hAA, 0); chk_obs("seed1", 1, 'h5A, 0); chk_obs("seed2", 2, 'hA5, 1);

      // Interleaved channels
      obs_q.delete();
      send(0, 'h11, 2, 0, 0); send(1, 'h22, 3, 0, 0); send(0, 'h44, 2, 0, 0);
      send(1, 'h88, 3, 0, 0); send(1, 'h01, 3, 0, 0);
      drain();
      chk_obs("ilv0", 0, 'h11, 0); chk_obs("ilv1", 1, 'h22, 0); chk_obs("ilv2", 2, 'h55, 1);
      chk_obs("ilv3", 3, 'hAA, 0); chk_obs("ilv4", 4, 'hAB, 1);

      // Length 1 with seed: every beat last
      for (int k = 0; k < 4; k++) send(1, $urandom_range(0, 255), 1, $urandom_range(0, 255), 1'b1);
      drain();

      // Length 0 clamps to MAX_WORDS
      obs_q.delete();
      for (int k = 0; k < TB_MAXW; k++) send(0, $urandom_range(0, 255), 0, 'h5C, 1'b1);
      drain();
      nl = 0;
      foreach (obs_q[k]) nl += obs_q[k].last;
      chk("len0_last_count", nl, 1);
      if (obs_q.size() != 0) chk("len0_final_last", obs_q[obs_q.size()-1].last, 1);

      // Backpressure mid-frame
      send(2, 'h31, 6, 'h07, 1'b1); send(2, 'h32, 6, 0, 0);
      rdy_force      = 1'b0;
      bus.i_in_valid = 1'b1;
      bus.i_in_chan  = TB_CHW'(2);
      bus.i_in_data  = 8'h33;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(bus.o_out_valid), 1);
         chk("bp_ready", 32'(bus.o_in_ready), 0);
         if (exp_q.size() != 0) chk("bp_data", 32'(bus.o_out_data), exp_q[0].data);
      end
      @(posedge clk); #1;
      bus.i_in_valid = 1'b0;
      rdy_force      = 1'b1;
      rand_ready     = 1'b1;
      for (int k = 3; k < 7; k++) send(2, 'h30 + k, 6, 0, 0);

      // Randomized interleaved traffic under random downstream stalls
      for (int n = 0; n < 300; n++) begin
         ch = ($urandom_range(0, 15) == 0) ? TB_NCH : $urandom_range(0, TB_NCH - 1);
         send(ch, $urandom_range(0, 255), $urandom_range(1, 6), $urandom_range(0, 255),
              1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_ready = 1'b0;
      drain();

      // Clear: abort partial frames, pending output still delivered
      bus.i_clear = 1'b1;
      @(posedge clk); #1;
      bus.i_clear = 1'b0;
      model_abort();
      send(0, 'hC1, 4, 0, 0); send(0, 'hC2, 4, 0, 0);
      obs_q.delete();
      rdy_force      = 1'b0;
      bus.i_clear    = 1'b1;
      bus.i_in_valid = 1'b1;
      bus.i_in_chan  = TB_CHW'(0);
      bus.i_in_data  = 8'h99;
      @(negedge clk);
      chk("clr_ready",   32'(bus.o_in_ready), 0);
      chk("clr_pending", 32'(bus.o_out_valid), 1);
      @(posedge clk); #1;
      bus.i_clear    = 1'b0;
      bus.i_in_valid = 1'b0;
      rdy_force      = 1'b1;
      model_abort();
      send(0, 'h3C, 4, 0, 0);
      drain();
      chk_obs("clr0", 0, 'h03, 0); chk_obs("clr1", 1, 'h3C, 0);

      // Asynchronous reset mid-frame
      send(1, 'hD1, 5, 0, 0); send(1, 'hD2, 5, 0, 0);
      rdy_force = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.o_out_valid), 0);
      chk("arst_data",  32'(bus.o_out_data), 0);
      chk("arst_ready", 32'(bus.o_in_ready), 0);
      exp_q.delete();
      model_abort();
      @(posedge clk); #1;
      rst_n     = 1'b1;
      rdy_force = 1'b1;
      @(negedge clk);
      chk("arst_rel_ready", 32'(bus.o_in_ready), 1);
      @(posedge clk); #1;
      obs_q.delete();
      send(1, 'h5A, 2, 0, 0); send(1, 'h0F, 2, 0, 0);
      drain();
      chk_obs("arst0", 0, 'h5A, 0); chk_obs("arst1", 1, 'h55, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ldpc_parity_backsub.md
# ldpc_parity_backsub

Multi-channel, parametrised dual-diagonal back-substitution engine for the LDPC encoder parity path. Each accepted word is XORed into a per-channel running accumulator, and the prefix-XOR result is emitted. Frame length is runtime-programmable per channel, with an optional per-frame seed word. The block sits between the H-matrix syndrome generator and the codeword packer, with full valid/ready backpressure on both sides.

## Interface
- `WIDTH`, default 8: data word width in bits (lifting size Z).
- `MAX_WORDS`, default 1024: maximum frame length in words, must be ≥2.
- `NUM_CH`, default 4: number of independent interleaved channels, must be ≥1.
- `i_clock`, in, 1: the block's single clock; all logic on the rising edge.
- `i_reset_n`, in, 1: reset, asynchronous and active-low. Assertion clears all state immediately; deassertion is synchronised externally.
- `i_clear`, in, 1: synchronous abort of all in-progress frames.
- `i_in_data`, in, WIDTH: syndrome word.
- `i_in_chan`, in, max(1,$clog2(NUM_CH)): channel of the current beat.
- `i_num_words`, in, $clog2(MAX_WORDS+1): frame length, sampled on a channel's first beat.
- `i_seed`, in, WIDTH: seed word, sampled on a channel's first beat.
- `i_seed_en`, in, 1: apply `i_seed` on the first beat.
- `i_in_valid`, in, 1: input beat valid.
- `o_in_ready`, out, 1: input beat accepted.
- `o_out_data`, out, WIDTH: parity word.
- `o_out_chan`, out, max(1,$clog2(NUM_CH)): channel of the output beat.
- `o_out_last`, out, 1: final word of the frame.
- `o_out_valid`, out, 1: output valid.
- `i_out_ready`, in, 1: downstream accept.

## Operation
- **Accept.** A beat is accepted when `i_in_valid` and `o_in_ready` are both high.
- **Per-channel state** for channel c:
  - `cnt[c]`: words accepted so far in the frame.
  - `acc[c]`: running XOR, WIDTH bits.
  - `len[c]`: latched frame length.
- **First beat** (`cnt[c]==0`):
  - `len[c]` is set to `i_num_words`. Values 0 or greater than MAX_WORDS are clamped to MAX_WORDS.
  - The effective accumulator is `i_seed` if `i_seed_en` is high, otherwise 0.
  - The stored `acc[c]` is ignored on this beat.
- **Every accepted beat:**
  - out = effective_acc ^ `i_in_data`.
  - `o_out_chan` = `i_in_chan`.
  - `o_out_last` = (`cnt[c]` == effective_len − 1).
- **Non-last beat:** `acc[c]` ← out and `cnt[c]` ← `cnt[c]`+1.
- **Last beat:** `cnt[c]` ← 0 and `acc[c]` ← 0. The next beat on c starts a new frame.
- **Length 1:** a frame of length 1 produces a single beat with `o_out_last`=1.
- **Channel independence:** channels are fully independent. Beats of different channels may interleave arbitrarily, and the per-channel order of outputs is preserved.
- **i_clear:** forces `o_in_ready` low in the same cycle and zeroes all `cnt`/`acc`/`len` at the next edge. A beat already held in the output register is still delivered.
- **Out-of-range channel:** `i_in_chan` ≥ NUM_CH is a protocol error. It is accepted but not output, and state is unchanged.

## Timing
- **Latency:** 1 cycle from acceptance to `o_out_valid`.
- **Ready:** `o_in_ready` = !`i_clear` && (!`o_out_valid` || `i_out_ready`). This is combinational from `i_out_ready`, with no bubble under continuous flow.
- **Throughput:** one word per cycle sustained, including back-to-back frames and channel switches.
- **Backpressure:** while `o_out_valid` is high and `i_out_ready` is low, all outputs hold stable and no beat is accepted.
- **Output register:** loaded on acceptance. It clears its valid when `i_out_ready` is high with no new beat, and is overwritten in the same cycle on simultaneous pop and push.
- **Reset values** (while `i_reset_n` is low):
  - `o_out_valid`=0, `o_out_data`=0, `o_out_chan`=0, `o_out_last`=0.
  - All `cnt`/`acc`/`len` are 0.
  - `o_in_ready`=0 during reset, and 1 in the first cycle after release.
- **Reset mid-frame:** partial frames are discarded with no output. The first beat after reset starts a new frame.
- **Same-cycle read and write:** on a beat to channel c, the state written is visible to the next beat on c in the following cycle. No hazard stall is allowed.

## Structure
- **Package `ldpc_backsub_pkg`:**
  - `chan_t` and `cnt_t` typedefs, sized from the parameters via localparams.
  - The `clamp_len` function.
  - Channel-state struct `{cnt, len, acc}`.
- **Sub-module `ldpc_backsub_out_reg`:** a one-entry valid/ready output register carrying {data, chan, last} and producing the ready term. It is reusable across the encoder.
- **Top level:** channel state array, first-beat/last-beat decode, XOR datapath.

## Test plan
- **Basic frame:** NUM_CH=1, WIDTH=8, len=4, no seed, inputs 0x01, 0x02, 0x04, 0x08 → outputs 0x01, 0x03, 0x07, 0x0F, with last only on 0x0F. Next frame 0x10 → 0x10.
- **Seed:** len=3, seed 0xA5 with `i_seed_en`=1, inputs 0x0F, 0xF0, 0xFF → outputs 0xAA, 0x5A, 0xA5, with last on the third.
- **Interleave:** 2 channels, len 2 and 3, beats ch0:0x11, ch1:0x22, ch0:0x44, ch1:0x88, ch1:0x01 → ch0: 0x11, 0x55(last); ch1: 0x22, 0xAA, 0xAB(last).
- **Backpressure:** hold `i_out_ready`=0 for 5 cycles mid-frame → outputs held stable and `o_in_ready`=0. Then randomly toggle `i_out_ready` → data sequence identical to the no-stall run, with no loss or duplication.
- **Boundaries:** `i_num_words`=0 → frame length MAX_WORDS, last on word 1024. `i_num_words`=1 → every beat last, output = input ^ seed.
- **Clear and reset:** `i_clear` after 2 of 4 words → `o_in_ready`=0 that cycle, and the pending output is still delivered. The next beat 0x3C → 0x3C (new frame). Asserting `i_reset_n` mid-frame → `o_out_valid` drops immediately, and the post-reset frame restarts from 0.
